// File: rtl/inst_fetch_if.sv
// Bus bundles for the fetch stage: the instruction-memory read port and the
// {inst, pc} hand-off to decode. "master" is the fetch side of each bus.

interface inst_fetch_imem_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface inst_fetch_dec_if;
   logic        valid;
   logic        ready;
   logic [31:0] inst;
   logic [31:0] pc;

   modport master (output valid, inst, pc, input ready);
   modport slave  (input valid, inst, pc, output ready);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues in-order word reads, buffers responses in a
// small FIFO and hands {inst, pc} to decode; redirects flush everything.

module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          MAX_OUTST  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   inst_fetch_imem_if.master       imem,
   inst_fetch_dec_if.master        dec,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTST + 1);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   entry_t        fifo_q [FIFO_DEPTH];
   entry_t        fifo_d [FIFO_DEPTH];

   logic   accept;
   logic   push;
   logic   pop;
   logic   fifo_empty;
   int     credits_used;
   entry_t head;
   logic   unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc[1:0];

   // Credits count buffered words plus kept in-flight reads, so every kept response has a slot.
   assign credits_used = int'(count_q) + int'(outst_q) - int'(drop_q);
   assign fifo_empty   = (count_q == '0);

   assign imem.req  = rst && !redirect && (int'(outst_q) < MAX_OUTST)
                      && (credits_used < FIFO_DEPTH);
   assign imem.addr = pc_q;
   assign accept    = imem.req && imem.gnt;

   assign head      = fifo_q[rd_ptr_q];
   assign dec.valid = !fifo_empty;
   assign dec.inst  = fifo_empty ? 32'h0 : head.inst;
   assign dec.pc    = fifo_empty ? 32'h0 : head.pc;
   assign pop       = !fifo_empty && dec.ready && !redirect;

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      outst_d   = outst_q;
      drop_d    = drop_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      fifo_d    = fifo_q;
      push      = 1'b0;

      if (redirect) begin
         pc_d      = {redirect_pc[31:2], 2'b00};
         resp_pc_d = {redirect_pc[31:2], 2'b00};
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         outst_d   = outst_q - OW'(imem.rvalid);
         drop_d    = outst_d;
      end else begin
         if (accept) begin
            pc_d = pc_q + 32'd4;
         end
         outst_d = outst_q + OW'(accept) - OW'(imem.rvalid);
         if (imem.rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - OW'(1);
            end else begin
               push             = 1'b1;
               fifo_d[wr_ptr_q] = '{inst: imem.rdata, pc: resp_pc_q};
               wr_ptr_d         = wr_ptr_q + PW'(1);
               resp_pc_d        = resp_pc_q + 32'd4;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         drop_q    <= '0;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         fifo_q    <= '{default: '0};
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         fifo_q    <= fifo_d;
      end
   end

endmodule
